press_classifier: RTL
=====================

// Module: press_classifier
// PURPOSE
//   Conditions the raw INC push-button and classifies each press as short or long, with auto-repeat while held.
//   Sits directly upstream of the mode FSM, clock counter and alarm setter; drives their inc_short/inc_long inputs.
//   Runs on the 10 kHz divided clock from clkdiv. Raw pin is asynchronous.
// PARAMETERS
//   DB_TICKS      200    debounce window in clk cycles (20 ms @ 10 kHz)
//   LONG_TICKS    10000  hold time in clk cycles that makes a press long (1 s)
//   REPEAT_TICKS  2000   auto-repeat period in clk cycles while long-held (200 ms)
//   CNT_W         14     counter width; must satisfy 2**CNT_W > max(DB_TICKS, LONG_TICKS, REPEAT_TICKS)
// PORTS
//   clk           in   1  10 kHz system clock (clk_10000Hz)
//   rst           in   1  asynchronous reset, active-high
//   btn_in        in   1  raw button pin, active-high, asynchronous, bouncy
//   btn_level     out  1  debounced button level
//   press_short   out  1  1-cycle pulse: press released before LONG_TICKS
//   press_long    out  1  1-cycle pulse: hold reached LONG_TICKS
//   press_repeat  out  1  1-cycle pulse every REPEAT_TICKS while long-held
//   long_active   out  1  high while in LONG_HELD
// BEHAVIOUR
//   Reset: sync FFs, stable level, all counters and all outputs = 0; state = IDLE.
//   Sync: 2-FF synchronizer on btn_in -> btn_s.
//   Debounce: db_cnt clears whenever btn_s == btn_level; otherwise increments.
//     At db_cnt == DB_TICKS-1, btn_level toggles and db_cnt clears.
//     A bounce shorter than DB_TICKS never changes btn_level.
//     Latency from raw edge to btn_level edge: 2 + DB_TICKS cycles.
//   rise/fall: 1-cycle strobes derived from btn_level vs. its registered copy.
//   FSM (all outputs registered; each pulse is high exactly one cycle):
//     IDLE:      rise -> PRESSED, hold_cnt = 0.
//     PRESSED:   hold_cnt++ each cycle.
//                fall -> press_short next cycle, go to IDLE.
//                hold_cnt == LONG_TICKS-1 and no fall -> press_long next cycle, go to LONG_HELD, rep_cnt = 0.
//                fall in the same cycle as threshold: release wins -> press_short only.
//     LONG_HELD: long_active = 1; rep_cnt++.
//                rep_cnt == REPEAT_TICKS-1 -> press_repeat pulse, rep_cnt = 0.
//                fall -> IDLE with no pulse; fall wins over a coincident repeat.
//   Exactly one of press_short or press_long is issued per press. press_repeat only follows press_long.
//   Counters never wrap: each is cleared on its terminal compare or on a state exit.
//   Reset mid-press: immediate return to IDLE, no pulse emitted.
//     If the button is still held after reset release, it is treated as a new press
//     (rise after 2 + DB_TICKS cycles).
//   Illegal state encoding -> IDLE.
// STRUCTURE
//   Shared package (clock_pkg):
//     - state localparams S_IDLE = 2'd0, S_PRESSED = 2'd1, S_LONG_HELD = 2'd2
//     - TICK_HZ = 10000
//     - default tick constants, also reused by the set/sw debouncers
//   Sub-module sync_debounce (#DB_TICKS, CNT_W): clk, rst, raw -> level.
//     Holds the synchronizer and debounce counter; instantiated once here.
//     Reusable to replace the existing debounce instances.
//   Top of this block: edge detect, FSM, hold/repeat counters, output registers.
// TESTING  (bench overrides DB_TICKS=4, LONG_TICKS=20, REPEAT_TICKS=5, CNT_W=6)
//   1. Bounce: toggle btn_in 1-0-1 at 2-cycle spacing, then idle low
//      -> btn_level stays 0; no pulses.
//   2. Short press: hold btn_in high 12 cycles
//      -> btn_level rises 6 cycles after the edge; one press_short after the fall; no press_long.
//   3. Long hold: hold high 40 cycles
//      -> press_long 20 cycles after btn_level rise; press_repeat every 5 cycles after that;
//         release -> long_active = 0 and no press_short.
//   4. Boundary: release so the fall strobe coincides with hold_cnt == 19
//      -> press_short only, no press_long.
//   5. Reset mid-hold: assert rst for 3 cycles during LONG_HELD while btn_in stays high
//      -> all outputs 0 immediately; new press_long 2+4+20 cycles after rst deasserts.
//   6. Back-to-back short presses separated by 6 low cycles
//      -> exactly two press_short pulses.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared definitions for the clock/alarm button front-ends: FSM state
// encoding, the system tick rate and default debounce/hold timing.
package clock_pkg;

  localparam int TICK_HZ = 10000;

  // Default timings in ticks of the 10 kHz clock.
  localparam int DEF_DB_TICKS     = 200;    // 20 ms
  localparam int DEF_LONG_TICKS   = 10000;  // 1 s
  localparam int DEF_REPEAT_TICKS = 2000;   // 200 ms
  localparam int DEF_CNT_W        = 14;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_PRESSED   = 2'd1,
    S_LONG_HELD = 2'd2
  } press_state_e;

endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchronizer followed by a counting debouncer. The level only
// flips once the synchronized input has disagreed with it for DB_TICKS
// consecutive cycles; any shorter excursion is discarded.
module sync_debounce
  import clock_pkg::*;
#(
  parameter int DB_TICKS = DEF_DB_TICKS,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_TICKS - 1);

  logic             s1_q, s2_q;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Debounce counter: clear on agreement, toggle level at the terminal count.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (s2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == DB_LAST) begin
      level_d = ~level_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Synchronizer and debounce state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      s1_q    <= raw;
      s2_q    <= s1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;

endmodule

// File: rtl/press_classifier.sv
// INC button front-end: debounces the raw pin, then classifies each press
// as short (released before LONG_TICKS) or long, and auto-repeats while a
// long press is held. All pulse outputs are registered, one cycle wide.
module press_classifier
  import clock_pkg::*;
#(
  parameter int DB_TICKS     = DEF_DB_TICKS,
  parameter int LONG_TICKS   = DEF_LONG_TICKS,
  parameter int REPEAT_TICKS = DEF_REPEAT_TICKS,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_level,
  output logic press_short,
  output logic press_long,
  output logic press_repeat,
  output logic long_active
);

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_TICKS - 1);

  press_state_e     state_q, state_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic [CNT_W-1:0] rep_q, rep_d;
  logic             level_prev_q;
  logic             short_q, short_d;
  logic             long_q, long_d;
  logic             repeat_q, repeat_d;
  logic             active_q, active_d;
  logic             rise, fall;

  sync_debounce #(
    .DB_TICKS(DB_TICKS),
    .CNT_W   (CNT_W)
  ) u_db (
    .clk  (clk),
    .rst  (rst),
    .raw  (btn_in),
    .level(btn_level)
  );

  assign rise = btn_level & ~level_prev_q;
  assign fall = ~btn_level & level_prev_q;

  // Next-state logic; a release always wins over a coincident threshold.
  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    rep_d    = rep_q;
    short_d  = 1'b0;
    long_d   = 1'b0;
    repeat_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        hold_d = '0;
        rep_d  = '0;
        if (rise) state_d = S_PRESSED;
      end
      S_PRESSED: begin
        if (fall) begin
          short_d = 1'b1;
          hold_d  = '0;
          state_d = S_IDLE;
        end else if (hold_q == LONG_LAST) begin
          long_d  = 1'b1;
          hold_d  = '0;
          rep_d   = '0;
          state_d = S_LONG_HELD;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      S_LONG_HELD: begin
        if (fall) begin
          rep_d   = '0;
          state_d = S_IDLE;
        end else if (rep_q == REP_LAST) begin
          repeat_d = 1'b1;
          rep_d    = '0;
        end else begin
          rep_d = rep_q + 1'b1;
        end
      end
      default: begin
        hold_d  = '0;
        rep_d   = '0;
        state_d = S_IDLE;
      end
    endcase
    active_d = (state_d == S_LONG_HELD);
  end

  // State, counters, edge-detect history and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      hold_q       <= '0;
      rep_q        <= '0;
      level_prev_q <= 1'b0;
      short_q      <= 1'b0;
      long_q       <= 1'b0;
      repeat_q     <= 1'b0;
      active_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      rep_q        <= rep_d;
      level_prev_q <= btn_level;
      short_q      <= short_d;
      long_q       <= long_d;
      repeat_q     <= repeat_d;
      active_q     <= active_d;
    end
  end

  assign press_short  = short_q;
  assign press_long   = long_q;
  assign press_repeat = repeat_q;
  assign long_active  = active_q;

endmodule
